// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, opcode constants and IR field positions for the CPU sequencer
package cpu_pkg;
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_LI    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_MOV   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_BEQ   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
endpackage

// File: rtl/cpu_seq_pc.sv
// cpu_seq_pc: program counter register with hold / increment (mod 2^AW) / load-target
// Ports: clk, rst_n (async active-low), inc, load (load wins), target[AW], pc[AW]
module cpu_seq_pc #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (load) pc <= target;
    else if (inc) pc <= pc + AW'(1);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute sequencer owning PC and IR, turning control-unit levels into timed strobes
// Ports: clk, rst_n (async active-low); imem_req/imem_addr/imem_ack/imem_rdata fetch handshake;
//   opcode/ir to the control unit; cu_reg_write/cu_mem_read/cu_mem_write/cu_pc_write, alu_zero in;
//   rf_we strobe; dmem_req/dmem_we/dmem_ack data handshake; pc; state (debug).
// Build option: CPU_SEQ_HALT_EN adds a HALT state for opcode 4'hF and a 'halted' output.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [3:0]    opcode,
  output logic [IW-1:0] ir,
  input  logic          cu_reg_write,
  input  logic          cu_mem_read,
  input  logic          cu_mem_write,
  input  logic          cu_pc_write,
  input  logic          alu_zero,
  output logic          rf_we,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ack,
  output logic [AW-1:0] pc,
`ifdef CPU_SEQ_HALT_EN
  output logic          halted,
`endif
  output logic [2:0]    state
);
  state_t st, nx;
  logic pc_inc, pc_load, ir_ld, halt_op;
  logic [AW-1:0] target;
  assign opcode    = ir[OPC_HI:OPC_LO];
  assign target    = AW'(ir[IMM_HI:IMM_LO]);
  assign imem_addr = pc;
  assign state     = st;
`ifdef CPU_SEQ_HALT_EN
  assign halt_op = opcode == OP_HALT;
  assign halted  = st == ST_HALT;
`else
  assign halt_op = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= ST_FETCH;
    else st <= nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ir <= '0;
    else if (ir_ld) ir <= imem_rdata;
  always_comb begin
    nx       = st;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    ir_ld    = 1'b0;
    case (st)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_ld    = imem_ack;
        nx       = imem_ack ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: nx = ST_EXEC;
      ST_EXEC: begin
        nx = ST_FETCH;
        if (halt_op) nx = ST_HALT;
        else if (cu_mem_read | cu_mem_write) nx = ST_MEM;
        else if (opcode == OP_JMP && cu_pc_write) pc_load = 1'b1;
        else if (opcode == OP_BEQ) begin
          pc_load = alu_zero;
          pc_inc  = !alu_zero;
        end else begin
          rf_we  = cu_reg_write;
          pc_inc = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        // mem_write wins when both are set, so such an instruction never writes the RF
        dmem_we  = cu_mem_write;
        rf_we    = dmem_ack & cu_mem_read & !cu_mem_write;
        pc_inc   = dmem_ack;
        nx       = dmem_ack ? ST_FETCH : ST_MEM;
      end
      ST_HALT: nx = ST_HALT;
      default: nx = ST_FETCH;
    endcase
    // strobes fall combinationally while reset is asserted, mid-handshake included
    if (!rst_n) begin
      imem_req = 1'b0;
      rf_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end
  cpu_seq_pc #(.AW(AW)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_inc),
    .load  (pc_load),
    .target(target),
    .pc    (pc)
  );
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench with an instruction-level model of the sequencer
module tb_cpu_sequencer;
`ifdef CPU_SEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
  logic halted;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, imem_ack = 1'b0, rf_we, dmem_req, dmem_we, dmem_ack = 1'b0, alu_zero = 1'b0;
  logic cu_reg_write, cu_mem_read, cu_mem_write, cu_pc_write;
  logic [7:0] imem_addr, pc;
  logic [15:0] imem_rdata = '0, ir;
  logic [3:0] opcode;
  logic [2:0] state;
  logic [3:0] cu_tab [16];
  int total = 0, bad = 0;
  int n_ireq = 0, n_rf = 0, n_dreq = 0, n_dwe = 0;
  logic chk_on = 1'b0;
  logic [7:0] m_pc = '0;
  logic [15:0] m_ir = '0;
  always #5 clk = ~clk;
  assign {cu_reg_write, cu_mem_read, cu_mem_write, cu_pc_write} = cu_tab[opcode];
  cpu_sequencer #(.AW(8), .IW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode(opcode), .ir(ir),
    .cu_reg_write(cu_reg_write), .cu_mem_read(cu_mem_read), .cu_mem_write(cu_mem_write),
    .cu_pc_write(cu_pc_write), .alu_zero(alu_zero),
    .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc(pc),
`ifdef CPU_SEQ_HALT_EN
    .halted(halted),
`endif
    .state(state)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_on && rst_n) begin
    n_ireq += int'(imem_req);
    n_rf   += int'(rf_we);
    n_dreq += int'(dmem_req);
    n_dwe  += int'(dmem_req & dmem_we);
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("opcode", 32'(opcode), 32'(m_ir[15:12]));
    if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("req_excl", 32'(imem_req & dmem_req), 0);
  end
  task automatic instr(input logic [15:0] w, input int iw, input int dw, input bit z, input bit noise);
    logic [3:0] op, f;
    logic [7:0] npc;
    bit mem, halt;
    int erf;
    op = w[15:12];
    f = cu_tab[op];
    mem = f[2] | f[1];
    halt = HALT_EN && op == 4'hF;
    erf = 0;
    if (halt) npc = m_pc;
    else if (mem) begin
      npc = m_pc + 8'd1;
      erf = int'(f[2] & !f[1]);
    end else if (op == 4'h8 && f[0]) npc = w[7:0];
    else if (op == 4'h9) npc = z ? w[7:0] : m_pc + 8'd1;
    else begin
      npc = m_pc + 8'd1;
      erf = int'(f[3]);
    end
    n_ireq = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
    alu_zero = z;
    repeat (iw) begin
      dmem_ack = noise;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = w;
    @(posedge clk); #1;
    m_ir = w;
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    @(posedge clk); #1;
    imem_ack = noise;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    if (mem && !halt) begin
      repeat (dw) begin @(posedge clk); #1; end
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    m_pc = npc;
    chk("n_imem_req", n_ireq, iw + 1);
    chk("n_rf_we", n_rf, erf);
    chk("n_dmem_req", n_dreq, (mem && !halt) ? dw + 1 : 0);
    chk("n_dmem_we", n_dwe, (mem && !halt && f[1]) ? dw + 1 : 0);
    if (halt) chk("state_halt", 32'(state), 4);
    else begin
      chk("state_next", 32'(state), 0);
      chk("imem_req_next", 32'(imem_req), 1);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) cu_tab[i] = 4'b0000;
    foreach (cu_tab[i]) if (i <= 4 || i == 7) cu_tab[i] = 4'b1000;
    cu_tab[5] = 4'b1100;
    cu_tab[6] = 4'b0010;
    cu_tab[8] = 4'b0001;
    cu_tab[9] = 4'b0001;
    #12;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_dmem", 32'({dmem_req, dmem_we}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_on = 1'b1;
    instr(16'h0500, 2, 0, 1'b0, 1'b0);
    chk("add_pc", 32'(pc), 32'h01);
    chk("add_next_addr", 32'(imem_addr), 32'h01);
    instr(16'h5142, 0, 2, 1'b0, 1'b0);
    chk("load_pc", 32'(pc), 32'h02);
    instr(16'h6233, 1, 1, 1'b0, 1'b0);
    chk("store_pc", 32'(pc), 32'h03);
    cu_tab[12] = 4'b0110;
    instr(16'hC000, 0, 0, 1'b0, 1'b0);
    instr(16'h7100, 2, 0, 1'b0, 1'b1);
    instr(16'hB000, 0, 0, 1'b1, 1'b0);
    chk("nop_pc", 32'(pc), 32'h06);
    instr(16'h8320, 1, 0, 1'b0, 1'b0);
    chk("jmp_pc", 32'(pc), 32'h20);
    instr(16'h9010, 0, 0, 1'b1, 1'b0);
    chk("beq_taken_pc", 32'(pc), 32'h10);
    instr(16'h80FF, 0, 0, 1'b0, 1'b0);
    instr(16'h9010, 0, 0, 1'b0, 1'b0);
    chk("beq_wrap_pc", 32'(pc), 32'h00);
    instr(16'h80FF, 0, 0, 1'b0, 1'b0);
    instr(16'h0400, 0, 0, 1'b0, 1'b0);
    chk("inc_wrap_pc", 32'(pc), 32'h00);
    instr(16'h1200, 0, 0, 1'b0, 1'b0);
    #2;
    chk("pre_rst_req", 32'(imem_req), 1);
    chk_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 0);
    chk("async_rst_pc", 32'(pc), 0);
    chk("async_rst_state", 32'(state), 0);
    m_pc = '0;
    m_ir = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_on = 1'b1;
    instr(16'h0100, 0, 0, 1'b0, 1'b0);
    instr(16'hF000, 1, 0, 1'b0, 1'b0);
`ifdef CPU_SEQ_HALT_EN
    chk("halted", 32'(halted), 1);
    n_ireq = 0; n_rf = 0; n_dreq = 0;
    repeat (20) begin @(posedge clk); #1; end
    chk("halt_imem_req", n_ireq, 0);
    chk("halt_strobes", n_rf + n_dreq, 0);
    chk("halt_pc", 32'(pc), 32'h01);
    chk("halt_state", 32'(state), 4);
`else
    chk("f_nop_pc", 32'(pc), 32'h02);
    instr(16'h0200, 0, 0, 1'b0, 1'b0);
    chk("f_resume_pc", 32'(pc), 32'h03);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
